// File: rtl/bram_lookup_client.sv
// Initiator for the bram_lookup 4-phase req/ack handshake: serialises table writes and
// MAC lookups one at a time, with a per-phase timeout guarding against a hung responder.
module bram_lookup_client #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 48,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_cmd_valid,
   input  logic [ADDR_W-1:0] wr_cmd_addr,
   input  logic [DATA_W-1:0] wr_cmd_data,
   output logic              wr_cmd_ready,
   output logic              wr_done,
   input  logic              lk_valid,
   input  logic [ADDR_W-1:0] lk_addr,
   output logic              lk_ready,
   output logic              lk_done,
   output logic [DATA_W-1:0] lk_data,
   output logic              lk_err,
   output logic [7:0]        timeout_cnt,
   output logic              bl_wr_req,
   output logic [ADDR_W-1:0] bl_wr_add,
   output logic [DATA_W-1:0] bl_wr_data,
   input  logic              bl_wr_ack,
   output logic              bl_read_req,
   output logic [ADDR_W-1:0] bl_rd_add,
   input  logic              bl_rd_ack,
   input  logic              bl_rd_valid,
   input  logic [DATA_W-1:0] bl_rd_data
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_HOLD = 3'd2,
      RD_REQ  = 3'd3,
      RD_HOLD = 3'd4,
      RD_WAIT = 3'd5,
      GAP     = 3'd6
   } state_t;

   localparam int          TMO_M1   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [15:0] TMO_LAST = 16'(TMO_M1);
   localparam bit          TMO_EN   = (TIMEOUT != 0);

   state_t              state_r, state_s;
   logic [15:0]         tmo_cnt_r, tmo_cnt_s;
   logic                gap_cnt_r, gap_cnt_s;
   logic                wr_req_r, wr_req_s;
   logic [ADDR_W-1:0]   wr_add_r, wr_add_s;
   logic [DATA_W-1:0]   wr_data_r, wr_data_s;
   logic                rd_req_r, rd_req_s;
   logic [ADDR_W-1:0]   rd_add_r, rd_add_s;
   logic                wr_done_r, wr_done_s;
   logic                lk_done_r, lk_done_s;
   logic [DATA_W-1:0]   lk_data_r, lk_data_s;
   logic                lk_err_r, lk_err_s;
   logic [7:0]          tmo_total_r, tmo_total_s;
   logic                idle_s, lk_accept_s, tmo_hit_s, tmo_fire_s, waiting_s;

   // A stale sticky rd_valid must clear before a new lookup may start.
   assign idle_s       = (state_r == IDLE);
   assign lk_accept_s  = idle_s & ~wr_cmd_valid & ~bl_rd_valid;
   assign tmo_hit_s    = TMO_EN & (tmo_cnt_r == TMO_LAST);
   assign wr_cmd_ready = idle_s;
   assign lk_ready     = lk_accept_s;

   assign wr_done      = wr_done_r;
   assign lk_done      = lk_done_r;
   assign lk_data      = lk_data_r;
   assign lk_err       = lk_err_r;
   assign timeout_cnt  = tmo_total_r;
   assign bl_wr_req    = wr_req_r;
   assign bl_wr_add    = wr_add_r;
   assign bl_wr_data   = wr_data_r;
   assign bl_read_req  = rd_req_r;
   assign bl_rd_add    = rd_add_r;

   // Next-state, next-output and timeout logic for the handshake sequencer.
   always_comb begin
      state_s     = state_r;
      gap_cnt_s   = 1'b0;
      wr_req_s    = wr_req_r;
      wr_add_s    = wr_add_r;
      wr_data_s   = wr_data_r;
      rd_req_s    = rd_req_r;
      rd_add_s    = rd_add_r;
      wr_done_s   = 1'b0;
      lk_done_s   = 1'b0;
      lk_err_s    = 1'b0;
      lk_data_s   = lk_data_r;
      tmo_total_s = tmo_total_r;
      tmo_fire_s  = 1'b0;
      waiting_s   = 1'b0;
      tmo_cnt_s   = 16'd0;
      case (state_r)
         IDLE: begin
            if (wr_cmd_valid) begin
               wr_add_s  = wr_cmd_addr;
               wr_data_s = wr_cmd_data;
               wr_req_s  = 1'b1;
               state_s   = WR_REQ;
            end else if (lk_valid && lk_accept_s) begin
               rd_add_s  = lk_addr;
               rd_req_s  = 1'b1;
               state_s   = RD_REQ;
            end else begin
               state_s   = IDLE;
            end
         end
         WR_REQ: begin
            waiting_s = 1'b1;
            if (bl_wr_ack) state_s = WR_HOLD;
            else           tmo_fire_s = tmo_hit_s;
         end
         WR_HOLD: begin
            waiting_s = 1'b1;
            if (!bl_wr_ack) begin
               wr_req_s  = 1'b0;
               wr_done_s = 1'b1;
               state_s   = GAP;
            end else begin
               tmo_fire_s = tmo_hit_s;
            end
         end
         RD_REQ: begin
            waiting_s = 1'b1;
            if (bl_rd_ack) state_s = RD_HOLD;
            else           tmo_fire_s = tmo_hit_s;
         end
         RD_HOLD: begin
            waiting_s = 1'b1;
            if (!bl_rd_ack) begin
               rd_req_s = 1'b0;
               state_s  = RD_WAIT;
            end else begin
               tmo_fire_s = tmo_hit_s;
            end
         end
         RD_WAIT: begin
            waiting_s = 1'b1;
            if (bl_rd_valid) begin
               lk_data_s = bl_rd_data;
               lk_done_s = 1'b1;
               state_s   = GAP;
            end else begin
               tmo_fire_s = tmo_hit_s;
            end
         end
         GAP: begin
            if (gap_cnt_r == 1'b1) state_s = IDLE;
            else                   gap_cnt_s = 1'b1;
         end
         default: state_s = IDLE;
      endcase

      // Abort: drop both reqs and report the operation that was in flight.
      if (tmo_fire_s) begin
         wr_req_s = 1'b0;
         rd_req_s = 1'b0;
         lk_err_s = 1'b0;
         state_s  = GAP;
         if ((state_r == WR_REQ) || (state_r == WR_HOLD)) begin
            wr_done_s = 1'b1;
         end else begin
            lk_done_s = 1'b1;
            lk_data_s = {DATA_W{1'b0}};
         end
         lk_err_s = 1'b1;
         if (tmo_total_r != 8'hFF) tmo_total_s = tmo_total_r + 8'd1;
         else                      tmo_total_s = tmo_total_r;
      end else begin
         tmo_total_s = tmo_total_r;
      end

      if (waiting_s && (state_s == state_r)) begin
         if (tmo_cnt_r != 16'hFFFF) tmo_cnt_s = tmo_cnt_r + 16'd1;
         else                       tmo_cnt_s = tmo_cnt_r;
      end else begin
         tmo_cnt_s = 16'd0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         tmo_cnt_r   <= 16'd0;
         gap_cnt_r   <= 1'b0;
         wr_req_r    <= 1'b0;
         wr_add_r    <= {ADDR_W{1'b0}};
         wr_data_r   <= {DATA_W{1'b0}};
         rd_req_r    <= 1'b0;
         rd_add_r    <= {ADDR_W{1'b0}};
         wr_done_r   <= 1'b0;
         lk_done_r   <= 1'b0;
         lk_data_r   <= {DATA_W{1'b0}};
         lk_err_r    <= 1'b0;
         tmo_total_r <= 8'd0;
      end else begin
         state_r     <= state_s;
         tmo_cnt_r   <= tmo_cnt_s;
         gap_cnt_r   <= gap_cnt_s;
         wr_req_r    <= wr_req_s;
         wr_add_r    <= wr_add_s;
         wr_data_r   <= wr_data_s;
         rd_req_r    <= rd_req_s;
         rd_add_r    <= rd_add_s;
         wr_done_r   <= wr_done_s;
         lk_done_r   <= lk_done_s;
         lk_data_r   <= lk_data_s;
         lk_err_r    <= lk_err_s;
         tmo_total_r <= tmo_total_s;
      end
   end

endmodule
